// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and load sign-extension.
// Accepts one load/store per handshake, issues it on a req/gnt/rvalid memory
// port with byte enables and lane-replicated store data, and returns load data
// aligned to bit 0 with unused upper bits zeroed.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned halfword (off=3) / word (off!=0) -> rsp_err, no access
//   undefined : no misalignment check; word uses off=0, halfword uses off&2'b10
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake from execute
//   req_we, req_funct3       store flag, RV32I load/store funct3
//   req_addr, req_wdata      byte address, store data (value in LSBs)
//   mem_req/mem_gnt          memory request handshake
//   mem_we, mem_addr         write strobe, word-aligned address
//   mem_be, mem_wdata        byte enables, lane-replicated store data
//   mem_rvalid, mem_rdata    read data return
//   rsp_valid/rsp_ready      response handshake to downstream
//   rsp_data, rsp_funct3     aligned zero-padded load data, funct3 of the op
//   rsp_err                  unsupported funct3 or trapped misalignment
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [2:0]            rsp_funct3,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  err_q;

  logic                  req_bad;
  logic [1:0]            off;
  logic [DATA_WIDTH-1:0] rdata_shifted;
  logic [DATA_WIDTH-1:0] load_aligned;
  logic [3:0]            be_calc;
  logic [DATA_WIDTH-1:0] wdata_rep;

  // Incoming request is answered with an error (no memory access) when the
  // funct3 is unsupported or, with trapping enabled, the access is misaligned.
  always_comb begin
    req_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11))
      req_bad = 1'b1;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
      req_bad = 1'b1;
`endif
  end

  // Effective byte offset of the latched access. Without trapping, the low
  // address bits a size cannot use are ignored to force natural alignment.
  always_comb begin
    off = 2'b00;
    unique case (f3_q[1:0])
      2'b00:   off = addr_q[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
      2'b01:   off = addr_q[1:0];
`else
      2'b01:   off = {addr_q[1], 1'b0};
`endif
      default: off = 2'b00;
    endcase
  end

  always_comb begin
    be_calc   = 4'b1111;
    wdata_rep = wdata_q;
    if (we_q) begin
      unique case (f3_q[1:0])
        2'b00:   begin be_calc = 4'b0001 << off; wdata_rep = {4{wdata_q[7:0]}};  end
        2'b01:   begin be_calc = 4'b0011 << off; wdata_rep = {2{wdata_q[15:0]}}; end
        default: begin be_calc = 4'b1111;        wdata_rep = wdata_q;            end
      endcase
    end else begin
      unique case (f3_q[1:0])
        2'b00:   wdata_rep = {4{wdata_q[7:0]}};
        2'b01:   wdata_rep = {2{wdata_q[15:0]}};
        default: wdata_rep = wdata_q;
      endcase
    end
  end

  // Words always have off=0, so the shifted word serves all three sizes.
  always_comb begin
    rdata_shifted = mem_rdata >> {off, 3'b000};
    unique case (f3_q[1:0])
      2'b00:   load_aligned = {24'b0, rdata_shifted[7:0]};
      2'b01:   load_aligned = {16'b0, rdata_shifted[15:0]};
      default: load_aligned = rdata_shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_bad ? RESP : REQ;
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_be    = be_calc;
        mem_wdata = wdata_rep;
        if (mem_gnt) state_nxt = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (mem_rvalid) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q       <= req_we;
        f3_q       <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        rsp_data_q <= '0;
        err_q      <= req_bad;
      end
      if (state == WAIT && mem_rvalid) rsp_data_q <= load_aligned;
    end
  end

  assign rsp_data   = rsp_data_q;
  assign rsp_funct3 = f3_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_funct3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_funct3(rsp_funct3), .rsp_err(rsp_err)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          g, r, stall;
  } op_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata, data;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: size from funct3, bytes picked/replicated by lane index.
  function automatic exp_t model(input op_t o);
    exp_t e;
    int   sz, off;
    logic unsup, mis;
    unsup = (o.f3 == 3'd3) || (o.f3 == 3'd6) || (o.f3 == 3'd7);
    sz    = (int'(o.f3) % 4 == 0) ? 1 : (int'(o.f3) % 4 == 1) ? 2 : 4;
    off   = int'(o.addr % 4);
    mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (sz == 2 && off == 3) || (sz == 4 && off != 0);
`else
    if (sz == 4) off = 0;
    if (sz == 2) off = (off / 2) * 2;
`endif
    e.err   = unsup || mis;
    e.addr  = o.addr - (o.addr % 4);
    e.be    = '0;
    e.wdata = '0;
    e.data  = '0;
    if (!e.err) begin
      if (o.we) for (int i = 0; i < sz; i++) e.be[off + i] = 1'b1;
      else      e.be = 4'hF;
      for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = o.wdata[8*(k % sz) +: 8];
      if (!o.we)
        for (int i = 0; i < sz; i++) e.data[8*i +: 8] = o.rdata[8*(off + i) +: 8];
    end
    e.cyc = e.err ? 1 : (o.we ? 2 + o.g : 3 + o.g + o.r);
    return e;
  endfunction

  task automatic run_op(input op_t o, input exp_t e);
    int          cyc = 1;
    int          gcnt = 0, rcnt = 0, scnt = 0;
    bit          seen_req = 0, gnt_prev = 0, granted = 0, rv_done = 0, done = 0;
    logic [31:0] held = '0;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = o.we;
    req_funct3 = o.f3;
    req_addr   = o.addr;
    req_wdata  = o.wdata;
    @(negedge clk);
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    while (!done && cyc < 200) begin
      if (gnt_prev) granted = 1;
      gnt_prev   = 0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      rsp_ready  = 1'b0;
      mem_rdata  = $urandom;
      if (mem_req) begin
        seen_req = 1;
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_be", {28'b0, mem_be}, {28'b0, e.be});
        chk("mem_we", {31'b0, mem_we}, {31'b0, o.we});
        chk("mem_wdata", mem_wdata, e.wdata);
        mem_rvalid = 1'($urandom % 2);  // stray rvalid before grant must be ignored
        if (gcnt == o.g) begin mem_gnt = 1'b1; gnt_prev = 1; end
        else gcnt++;
      end
      if (granted && !o.we && !rv_done) begin
        if (rcnt == o.r) begin
          mem_rvalid = 1'b1;
          mem_rdata  = o.rdata;
          rv_done    = 1;
        end else rcnt++;
      end
      if (rsp_valid) begin
        chk("req_ready_resp", {31'b0, req_ready}, 32'd0);
        if (scnt == 0) begin
          chk("rsp_cycle", cyc, e.cyc);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          chk("rsp_funct3", {29'b0, rsp_funct3}, {29'b0, o.f3});
          held = rsp_data;
        end else begin
          chk("rsp_data_stable", rsp_data, held);
        end
        if (scnt == o.stall) begin rsp_ready = 1'b1; done = 1; end
        else scnt++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("op_completed", {31'b0, done}, 32'd1);
    rsp_ready  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    chk("mem_req_issued", {31'b0, seen_req}, {31'b0, !e.err});
    chk("rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
  endtask

  vec_t vt[8];

  initial begin
    rst = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; rsp_ready = 0;

    //            we    f3    addr        wdata         rdata        g  r  st     addr        be     wdata         data          err cyc
    vt[0] = '{'{1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0,        0, 0, 0}, '{32'h104, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 2}};
    vt[1] = '{'{1'b1, 3'd0, 32'h203, 32'h000000A5, 32'h0,        0, 0, 0}, '{32'h200, 4'h8, 32'hA5A5A5A5, 32'h0,        1'b0, 2}};
    vt[2] = '{'{1'b0, 3'd0, 32'h101, 32'h0,        32'h1234F678, 0, 3, 0}, '{32'h100, 4'hF, 32'h0,        32'h000000F6, 1'b0, 6}};
    vt[3] = '{'{1'b0, 3'd5, 32'h102, 32'h0,        32'h8001ABCD, 0, 0, 4}, '{32'h100, 4'hF, 32'h0,        32'h00008001, 1'b0, 3}};
`ifdef LSU_MISALIGN_TRAP_EN
    vt[4] = '{'{1'b0, 3'd2, 32'h102, 32'h0,        32'hCAFEF00D, 0, 0, 0}, '{32'h100, 4'hF, 32'h0,        32'h0,        1'b1, 1}};
    vt[7] = '{'{1'b0, 3'd1, 32'h103, 32'h0,        32'hAABBCCDD, 1, 1, 0}, '{32'h100, 4'hF, 32'h0,        32'h0,        1'b1, 1}};
`else
    vt[4] = '{'{1'b0, 3'd2, 32'h102, 32'h0,        32'hCAFEF00D, 0, 0, 0}, '{32'h100, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0, 3}};
    vt[7] = '{'{1'b0, 3'd1, 32'h103, 32'h0,        32'hAABBCCDD, 1, 1, 0}, '{32'h100, 4'hF, 32'h0,        32'h0000AABB, 1'b0, 5}};
`endif
    vt[5] = '{'{1'b0, 3'd3, 32'h100, 32'h0,        32'h12345678, 0, 0, 0}, '{32'h100, 4'hF, 32'h0,        32'h0,        1'b1, 1}};
    vt[6] = '{'{1'b1, 3'd1, 32'h102, 32'h1234BEEF, 32'h0,        2, 0, 1}, '{32'h100, 4'hC, 32'hBEEFBEEF, 32'h0,        1'b0, 4}};

    // Reset values
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_op(vt[i].op, vt[i].e);

    // Reset while waiting for read data; a late rvalid must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rwait_mem_req", {31'b0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rwait_in_wait", {31'b0, mem_req}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rwait_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rwait_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rwait_mem_addr", mem_addr, 32'd0);
    chk("rwait_rsp_funct3", {29'b0, rsp_funct3}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rwait_no_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("rwait_idle", {31'b0, req_ready}, 32'd1);
      chk("rwait_rsp_data", rsp_data, 32'd0);
      @(negedge clk);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      op_t o;
      o.we    = 1'($urandom % 2);
      o.f3    = 3'($urandom % 8);
      o.addr  = $urandom;
      o.wdata = $urandom;
      o.rdata = $urandom;
      o.g     = int'($urandom % 3);
      o.r     = int'($urandom % 3);
      o.stall = int'($urandom % 3);
      run_op(o, model(o));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
